// File: rtl/stage4_mem_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, default timeout
// constants and the byte-to-word address helper.
package stage4_mem_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam int unsigned DefTimeout = 255;
  localparam int unsigned DefCntW    = 8;

  // Data memory is word addressed; low byte-offset bits are cleared.
  function automatic logic [31:0] word_addr(logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/stage4_mem_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the
// external data memory (slave).
interface stage4_mem_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/stage4_mem_dmem_ctl.sv
// Data-memory access controller: IDLE/WAIT FSM, wait-state timeout counter,
// request/stall generation, completion and abort strobes, sticky bus error.
module stage4_mem_dmem_ctl
  import stage4_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic ready,
  output logic req,
  output logic stall,
  output logic done,
  output logic abort,
  output logic bus_err
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             at_limit;

  assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

  // Request/stall decode; gated by reset so the bus drops as soon as rst_n falls.
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    if (rst_n) begin
      unique case (state)
        StIdle: begin
          req   = acc;
          done  = acc & ready;
          stall = acc & ~ready;
        end
        StWait: begin
          req   = 1'b1;
          done  = ready;
          abort = ~ready & at_limit;
          stall = ~ready & ~at_limit;
        end
        default: ;
      endcase
    end
  end

  // FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (acc && !ready) begin
            state <= StWait;
            cnt   <= '0;
          end
        end
        StWait: begin
          if (ready || at_limit) begin
            state <= StIdle;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
      if (abort) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage4_mem.sv
// MEM stage of the five-stage MIPS pipeline: drives the data-memory bus,
// stalls upstream during wait states, resolves the branch and holds the
// MEM/WB register. Optional misaligned-access trap: STAGE4_ALIGN_CHECK_EN.
module stage4_mem
  import stage4_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alurslt,
  input  logic [31:0] data2,
  input  logic [4:0]  wrreg,
  input  logic        zero,
  input  logic [31:0] pc4,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        branch,
  input  logic        regwrite,
  input  logic        memtoreg,
  output logic        pcsrc,
  output logic [31:0] baddr,
  output logic        stall,
  stage4_mem_if.master dmem,
  output logic [31:0] rdata_out,
  output logic [31:0] alurslt_out,
  output logic [4:0]  wrreg_out,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic        bus_err
`ifdef STAGE4_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  logic acc;
  logic is_load;
  logic misalign;
  logic mem_acc;
  logic done;
  logic abort;

  // A store wins when both requests are set.
  assign acc     = memread | memwrite;
  assign is_load = memread & ~memwrite;

`ifdef STAGE4_ALIGN_CHECK_EN
  assign misalign = acc & (alurslt[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Misaligned accesses never reach the bus.
  assign mem_acc = acc & ~misalign;

  stage4_mem_dmem_ctl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dmem_ctl (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc     (mem_acc),
    .ready   (dmem.dmem_ready),
    .req     (dmem.dmem_req),
    .stall   (stall),
    .done    (done),
    .abort   (abort),
    .bus_err (bus_err)
  );

  assign dmem.dmem_we    = memwrite;
  assign dmem.dmem_addr  = word_addr(alurslt);
  assign dmem.dmem_wdata = data2;

  assign pcsrc = branch & zero;
  assign baddr = pc4;

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_out    <= '0;
      alurslt_out  <= '0;
      wrreg_out    <= '0;
      regwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
    end else if (stall) begin
      regwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
    end else begin
      alurslt_out  <= alurslt;
      wrreg_out    <= wrreg;
      regwrite_out <= regwrite & ~abort & ~misalign;
      memtoreg_out <= memtoreg;
      rdata_out    <= (done && is_load) ? dmem.dmem_rdata : '0;
    end
  end

`ifdef STAGE4_ALIGN_CHECK_EN
  // Sticky misaligned-access flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (misalign) begin
      align_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem: directed scenarios followed by random
// instructions checked against a transaction-level reference model.
module tb_stage4_mem;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alurslt, data2, pc4;
  logic [4:0]  wrreg;
  logic        zero, memread, memwrite, branch, regwrite, memtoreg;
  logic        pcsrc, stall;
  logic [31:0] baddr;
  logic [31:0] rdata_out, alurslt_out;
  logic [4:0]  wrreg_out;
  logic        regwrite_out, memtoreg_out, bus_err;
`ifdef STAGE4_ALIGN_CHECK_EN
  logic        align_err;
`endif

  stage4_mem_if dmem ();

  stage4_mem #(
    .TIMEOUT (T),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alurslt      (alurslt),
    .data2        (data2),
    .wrreg        (wrreg),
    .zero         (zero),
    .pc4          (pc4),
    .memread      (memread),
    .memwrite     (memwrite),
    .branch       (branch),
    .regwrite     (regwrite),
    .memtoreg     (memtoreg),
    .pcsrc        (pcsrc),
    .baddr        (baddr),
    .stall        (stall),
    .dmem         (dmem.master),
    .rdata_out    (rdata_out),
    .alurslt_out  (alurslt_out),
    .wrreg_out    (wrreg_out),
    .regwrite_out (regwrite_out),
    .memtoreg_out (memtoreg_out),
    .bus_err      (bus_err)
`ifdef STAGE4_ALIGN_CHECK_EN
    ,
    .align_err    (align_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Expected MEM/WB contents and sticky error.
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_wr;
  logic        m_rw, m_mtr, m_berr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_alu   = '0;
    m_rdata = '0;
    m_wr    = '0;
    m_rw    = 1'b0;
    m_mtr   = 1'b0;
    m_berr  = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    check({tag, ".alurslt_out"}, alurslt_out, m_alu);
    check({tag, ".wrreg_out"}, 32'(wrreg_out), 32'(m_wr));
    check({tag, ".regwrite_out"}, 32'(regwrite_out), 32'(m_rw));
    check({tag, ".memtoreg_out"}, 32'(memtoreg_out), 32'(m_mtr));
    check({tag, ".rdata_out"}, rdata_out, m_rdata);
    check({tag, ".bus_err"}, 32'(bus_err), 32'(m_berr));
  endtask

  task automatic zero_inputs();
    alurslt  = '0;
    data2    = '0;
    pc4      = '0;
    wrreg    = '0;
    zero     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
  endtask

  // One instruction from issue to MEM/WB load. Called just after a rising edge.
  // w = cycles before the memory answers; w > T means it never answers in time.
  task automatic run_instr(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] wr, input logic z, input logic mr,
                           input logic mw, input logic br, input logic rw,
                           input logic mtr, input logic [31:0] p, input int w,
                           input logic [31:0] rd);
    logic acc;
    int   n_stall;
    logic abort;
    acc     = mr | mw;
    n_stall = acc ? ((w < int'(T)) ? w : int'(T)) : 0;
    abort   = acc && (w > int'(T));
    alurslt = a; data2 = d; wrreg = wr; zero = z; memread = mr; memwrite = mw;
    branch = br; regwrite = rw; memtoreg = mtr; pc4 = p;
    for (int c = 0; c <= n_stall; c++) begin
      dmem.dmem_ready = acc ? (c == w) : 1'($urandom);
      dmem.dmem_rdata = (acc && c == w) ? rd : $urandom;
      @(negedge clk);
      check({tag, ".stall"}, 32'(stall), 32'(c < n_stall));
      check({tag, ".req"}, 32'(dmem.dmem_req), 32'(acc));
      check({tag, ".pcsrc"}, 32'(pcsrc), 32'(br & z));
      check({tag, ".baddr"}, baddr, p);
      if (acc) begin
        check({tag, ".we"}, 32'(dmem.dmem_we), 32'(mw));
        check({tag, ".addr"}, dmem.dmem_addr, {a[31:2], 2'b00});
        check({tag, ".wdata"}, dmem.dmem_wdata, d);
      end
      @(posedge clk);
      #1;
      if (c < n_stall) begin
        m_rw  = 1'b0;
        m_mtr = 1'b0;
      end else begin
        m_alu   = a;
        m_wr    = wr;
        m_rw    = rw & ~abort;
        m_mtr   = mtr;
        m_rdata = (mr && !mw && !abort) ? rd : '0;
        if (abort) m_berr = 1'b1;
      end
      check_wb(tag);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    rst_n = 1'b0;
    zero_inputs();
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = '0;
    model_clear();
    #12;
    check("rst.req", 32'(dmem.dmem_req), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check_wb("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_wb("rst_rel");

    // ALU op, store zero-wait, load with 3 wait states.
    run_instr("alu", 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              32'h4, 0, 32'h0);
    run_instr("st0", 32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
              32'h8, 0, 32'h0);
    run_instr("ld3", 32'h80, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              32'hC, 3, 32'hCAFEF00D);
    // Branch resolution.
    run_instr("brt", 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              32'h100, 0, 32'h0);
    run_instr("brn", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              32'h100, 0, 32'h0);
    // Wait exactly T cycles completes; beyond T aborts and sets sticky bus_err.
    run_instr("ldT", 32'h84, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              32'h10, int'(T), 32'h1111_2222);
    run_instr("tmo", 32'h88, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              32'h14, 100, 32'h0);
    run_instr("stky", 32'h55, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              32'h18, 0, 32'h0);

    // Reset asserted during WAIT with the load still presented.
    zero_inputs();
    alurslt = 32'h80;
    memread = 1'b1;
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    check("rwait.stall_pre", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rwait.req", 32'(dmem.dmem_req), 32'd0);
    check("rwait.stall", 32'(stall), 32'd0);
    check_wb("rwait");
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr("ldpost", 32'hA0, 32'h0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              32'h20, 2, 32'h0BAD_F00D);

    // Random instruction mix.
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 4));
      a    = $urandom;
`ifdef STAGE4_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      run_instr("rnd", a, $urandom, 5'($urandom), 1'($urandom),
                (kind == 1) || (kind == 3), (kind == 2) || (kind == 3), (kind == 4),
                1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)),
                $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stage4_mem.md
Name: stage4_mem

Overview:
- Memory-access (MEM) stage of the five-stage MIPS CPU, directly downstream of the execute stage.
- Consumes the EX/MEM values: ALU result, store data, write-register number, zero flag and branch target.
- Performs loads and stores through a ready/request handshake to an external data memory, stalling the pipeline while the memory is busy.
- Resolves the branch (PCSrc) and drives the registered MEM/WB outputs consumed by write-back.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before a data-memory access is aborted (range 1..255).
- CNT_W, 8: width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alurslt  in  32  EX/MEM ALU result; memory byte address
- data2  in  32  EX/MEM store data
- wrreg  in  5  EX/MEM destination register
- zero  in  1  EX/MEM ALU zero flag
- pc4  in  32  EX/MEM branch target
- memread  in  1  load request
- memwrite  in  1  store request
- branch  in  1  instruction is a branch
- regwrite  in  1  write-back enable
- memtoreg  in  1  write-back selects memory data
- pcsrc  out  1  branch taken (combinational)
- baddr  out  32  branch target to fetch (combinational, equals pc4)
- stall  out  1  hold IF/ID/EX stages and EX/MEM inputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {alurslt[31:2],2'b00}
- dmem_wdata  out  32  equals data2
- dmem_ready  in  1  memory completes access this cycle
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- rdata_out  out  32  MEM/WB load data
- alurslt_out  out  32  MEM/WB ALU result
- wrreg_out  out  5  MEM/WB destination register
- regwrite_out  out  1  MEM/WB write enable
- memtoreg_out  out  1  MEM/WB select
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: all registered outputs 0, bus_err=0, state IDLE, counter 0. Asserting rst_n low mid-WAIT returns to IDLE asynchronously and drops dmem_req immediately.
- Access: acc = memread | memwrite.
  - memwrite has priority. When both are set, the access is a store and rdata_out is 0.
  - dmem_we = memwrite.
- IDLE:
  - dmem_req = acc (combinational).
  - acc with dmem_ready=1 is a zero-wait completion: no stall, MEM/WB register loads at the clock edge.
  - acc with dmem_ready=0: stall=1, go to WAIT, counter cleared.
- WAIT:
  - dmem_req=1 and stall=1 until completion. Upstream holds the EX/MEM inputs constant while stall=1.
  - dmem_ready=1 completes: stall=0 that cycle, MEM/WB loads, return to IDLE.
  - Counter increments each WAIT cycle without ready.
  - When counter==TIMEOUT-1 and no ready: abort. stall=0 that cycle, bus_err set (sticky until reset), MEM/WB loads with regwrite_out forced to 0, return to IDLE.
- MEM/WB register:
  - Loads every cycle when stall=0.
  - While stall=1 it loads a bubble (regwrite_out=0, memtoreg_out=0, other fields hold).
  - rdata_out captures dmem_rdata on load completion, else 0.
- Branch: pcsrc = branch & zero, independent of stall. Branches never carry acc.
- Non-memory instructions pass through with 1-cycle latency. Memory instructions take 1 + wait-state cycles.

Optional Feature:
- Macro: STAGE4_ALIGN_CHECK_EN.
- Defined: an access with alurslt[1:0]!=0 issues no dmem_req and no stall. The MEM/WB register loads with regwrite_out=0, and a sticky output align_err (1 bit, reset 0) is set.
- Undefined: the align_err port is absent, and the low address bits are silently dropped by dmem_addr.

Decomposition:
- Shared include file mem_defs.v holds the FSM state encodings (IDLE=1'b0, WAIT=1'b1) and the default TIMEOUT constant.
- One sub-module is natural: dmem_ctl, containing the FSM, timeout counter, and the req/stall/abort logic. stage4_mem holds the MEM/WB register and the branch logic.

Test Plan:
- ALU op with regwrite=1, alurslt=0x1234, wrreg=5 → next edge: alurslt_out=0x1234, wrreg_out=5, regwrite_out=1; stall never asserted.
- Store to 0x40, data2=0xDEADBEEF, dmem_ready tied 1 → dmem_req=1, dmem_we=1, dmem_addr=0x40, dmem_wdata=0xDEADBEEF in a single cycle, stall=0.
- Load from 0x80, ready after 3 cycles with rdata=0xCAFEF00D → stall high exactly 3 cycles with regwrite_out=0 bubbles, then rdata_out=0xCAFEF00D, memtoreg_out=1.
- TIMEOUT=4, dmem_ready held 0 → stall for 4 cycles then released; bus_err=1 and stays 1; regwrite_out=0 for that load.
- branch=1, zero=1, pc4=0x100 → pcsrc=1, baddr=0x100 same cycle; with zero=0 → pcsrc=0.
- rst_n low during WAIT → dmem_req and stall drop immediately; all outputs 0. After release, a new load completes normally.
